branch_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage RV32 pipeline. Sits beside the IF stage: the fetch PC looks it up combinationally to choose the next PC, and the EX stage writes back resolved branch and jump outcomes. It adds speculative redirection and mispredict detection to a pipeline that otherwise always fetches PC+4 and flushes on every taken branch.

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters for the RV32 fetch stage.
// Optional performance counters are built when BP_PERF_EN is defined.
module branch_predictor #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = {1'b1, {(CNT_W-1){1'b0}}};

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;

  logic             wr_en;
  logic             wr_jump;
  logic [CNT_W-1:0] wr_cnt;
  logic [PC_W-1:0]  wr_tgt;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = if_pc[IDX_W+1:2];
  assign lk_tag  = if_pc[PC_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup reads the table as it stands: an update in the same cycle is not bypassed.
  // Gated by reset so the prediction is quiet while reset is held.
  always_comb begin
    pred_taken  = reset && lk_hit && (jump_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);
    pred_target = pred_taken ? tgt_q[lk_idx] : '0;
  end

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  always_comb begin
    wr_en   = 1'b0;
    wr_jump = jump_q[upd_idx];
    wr_cnt  = cnt_q[upd_idx];
    wr_tgt  = tgt_q[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          wr_jump = 1'b1;
          wr_tgt  = upd_target;
        end else begin
          wr_jump = 1'b0;
          if (upd_taken) begin
            wr_tgt = upd_target;
            if (cnt_q[upd_idx] != CNT_MAX) wr_cnt = cnt_q[upd_idx] + CNT_W'(1);
          end else if (cnt_q[upd_idx] != '0) begin
            wr_cnt = cnt_q[upd_idx] - CNT_W'(1);
          end
        end
      end else if (upd_taken) begin
        wr_en   = 1'b1;
        wr_jump = upd_is_jump;
        wr_cnt  = CNT_WEAK;
        wr_tgt  = upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
      jump_q[upd_idx]  <= wr_jump;
      cnt_q[upd_idx]   <= wr_cnt;
    end
  end

  // Tags and targets carry no reset; a cleared valid bit hides them.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= wr_tgt;
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (upd_valid)  br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign perf_branches    = br_cnt_q;
  assign perf_mispredicts = mp_cnt_q;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (PC_W=9, ENTRIES=16, CNT_W=2).
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [8:0]  if_pc;
  logic        pred_taken;
  logic [8:0]  pred_target;
  logic        upd_valid;
  logic [8:0]  upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [8:0]  upd_target;
  logic        upd_pred_taken;
  logic [8:0]  upd_pred_target;
  logic        mispredict;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BP_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  branch_predictor #(.PC_W(9), .ENTRIES(16), .CNT_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_pc           (if_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_jump     (upd_is_jump),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [8:0] pc, input logic exp_t, input logic [8:0] exp_tgt);
    if_pc = pc;
    #3;
    check({tag, ".taken"}, 32'(pred_taken), 32'(exp_t));
    check({tag, ".target"}, 32'(pred_target), 32'(exp_tgt));
    next_cycle();
  endtask

  task automatic upd(input string tag, input logic [8:0] pc, input logic jmp, input logic tk,
                     input logic [8:0] tgt, input logic ptk, input logic [8:0] ptgt,
                     input logic exp_misp);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_jump     = jmp;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    #3;
    check({tag, ".mispredict"}, 32'(mispredict), 32'(exp_misp));
    next_cycle();
    upd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    repeat (3) next_cycle();
    reset = 1'b1;

    // Post-reset: empty table, quiet outputs
    look("rst_000", 9'h000, 1'b0, 9'h000);
    look("rst_004", 9'h004, 1'b0, 9'h000);
    look("rst_1fc", 9'h1FC, 1'b0, 9'h000);
    check("rst_misp_idle", 32'(mispredict), 32'd0);
    check("rst_perf_br", perf_branches, 32'd0);
    check("rst_perf_mp", perf_mispredicts, 32'd0);

    // Allocation and counter saturation at 0x010 (index 4)
    upd("alloc", 9'h010, 1'b0, 1'b1, 9'h040, 1'b0, 9'h000, 1'b1);
    look("alloc_lk", 9'h010, 1'b1, 9'h040);
    upd("tk1", 9'h010, 1'b0, 1'b1, 9'h040, 1'b1, 9'h040, 1'b0);
    look("tk1_lk", 9'h010, 1'b1, 9'h040);
    upd("tk2", 9'h010, 1'b0, 1'b1, 9'h040, 1'b1, 9'h040, 1'b0);
    look("tk2_lk", 9'h010, 1'b1, 9'h040);
    upd("nt1", 9'h010, 1'b0, 1'b0, 9'h000, 1'b1, 9'h040, 1'b1);
    look("nt1_lk", 9'h010, 1'b1, 9'h040);
    upd("nt2", 9'h010, 1'b0, 1'b0, 9'h000, 1'b1, 9'h040, 1'b1);
    look("nt2_lk", 9'h010, 1'b0, 9'h000);
    upd("nt3", 9'h010, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0);
    look("nt3_lk", 9'h010, 1'b0, 9'h000);
    upd("nt4", 9'h010, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0);
    look("nt4_lk", 9'h010, 1'b0, 9'h000);
    upd("nt_miss", 9'h020, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0);
    look("nt_miss_lk", 9'h020, 1'b0, 9'h000);

    // Counter 0 -> 1 -> 2, then aliasing at index 4 with a jump
    upd("rec1", 9'h010, 1'b0, 1'b1, 9'h040, 1'b0, 9'h000, 1'b1);
    look("rec1_lk", 9'h010, 1'b0, 9'h000);
    upd("rec2", 9'h010, 1'b0, 1'b1, 9'h040, 1'b0, 9'h000, 1'b1);
    look("rec2_lk", 9'h010, 1'b1, 9'h040);
    upd("alias_j", 9'h050, 1'b1, 1'b1, 9'h100, 1'b0, 9'h000, 1'b1);
    look("alias_old", 9'h010, 1'b0, 9'h000);
    look("alias_new", 9'h050, 1'b1, 9'h100);
    upd("j_nt", 9'h050, 1'b1, 1'b0, 9'h100, 1'b1, 9'h100, 1'b1);
    look("j_nt_lk", 9'h050, 1'b1, 9'h100);
    upd("j_newtgt", 9'h050, 1'b1, 1'b1, 9'h120, 1'b1, 9'h100, 1'b1);
    look("j_newtgt_lk", 9'h050, 1'b1, 9'h120);
    upd("br_clr_j", 9'h050, 1'b0, 1'b0, 9'h000, 1'b1, 9'h120, 1'b1);
    look("br_clr_j_lk", 9'h050, 1'b0, 9'h000);

    // Same-cycle lookup and allocating update: no bypass
    if_pc = 9'h030;
    upd_valid = 1'b1; upd_pc = 9'h030; upd_is_jump = 1'b0; upd_taken = 1'b1;
    upd_target = 9'h0A0; upd_pred_taken = 1'b0; upd_pred_target = 9'h000;
    #3;
    check("hz_same.taken", 32'(pred_taken), 32'd0);
    check("hz_same.mispredict", 32'(mispredict), 32'd1);
    next_cycle();
    upd_valid = 1'b0;
    look("hz_next", 9'h030, 1'b1, 9'h0A0);

    // Mid-run reset, then 5 updates with 2 mispredicts
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    check("rst2_perf_br", perf_branches, 32'd0);
    look("rst2_010", 9'h010, 1'b0, 9'h000);
    look("rst2_030", 9'h030, 1'b0, 9'h000);
    upd("p1", 9'h010, 1'b0, 1'b1, 9'h040, 1'b0, 9'h000, 1'b1);
    upd("p2", 9'h010, 1'b0, 1'b1, 9'h040, 1'b1, 9'h040, 1'b0);
    upd("p3", 9'h020, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0);
    upd("p4", 9'h030, 1'b1, 1'b1, 9'h080, 1'b0, 9'h000, 1'b1);
    upd("p5", 9'h030, 1'b1, 1'b1, 9'h080, 1'b1, 9'h080, 1'b0);
    check("perf_br", perf_branches, PERF ? 32'd5 : 32'd0);
    check("perf_mp", perf_mispredicts, PERF ? 32'd2 : 32'd0);
    look("pre_rst_030", 9'h030, 1'b1, 9'h080);

    // Reset alongside an allocating update: update discarded, table cleared
    reset = 1'b0;
    if_pc = 9'h010;
    upd_valid = 1'b1; upd_pc = 9'h060; upd_is_jump = 1'b0; upd_taken = 1'b1;
    upd_target = 9'h0C0; upd_pred_taken = 1'b0; upd_pred_target = 9'h000;
    #3;
    check("rst3_misp", 32'(mispredict), 32'd1);
    check("rst3_quiet", 32'(pred_taken), 32'd0);
    next_cycle();
    upd_valid = 1'b0;
    reset = 1'b1;
    check("rst3_perf_br", perf_branches, 32'd0);
    check("rst3_perf_mp", perf_mispredicts, 32'd0);
    look("rst3_010", 9'h010, 1'b0, 9'h000);
    look("rst3_030", 9'h030, 1'b0, 9'h000);
    look("rst3_060", 9'h060, 1'b0, 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
